cic_integrator_chain: RTL and testbench

Multi-channel, multi-order integrator section for the CIC decimation path. It replaces a single integrator stage with a pipelined chain of ORDER integrators per channel, time-multiplexed over CH channels. Register growth is selectable at run time from the oversampling setting. The block sits between the input sample source and the decimator/comb section, and hands each channel's final-stage integrator value downstream with a channel tag.

---
 rtl/cic_integrator_chain.sv | 107 ++++++++++
 tb/tb_cic_integrator_chain.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_integrator_chain.sv
// Pipelined, time-multiplexed CIC integrator chain: ORDER cascaded integrators per channel,
// with run-time register growth (wrap width) selected by the oversampling shadow.
module cic_integrator_chain #(
   parameter  int IDW         = 16,
   parameter  int ORDER       = 3,
   parameter  int CH          = 2,
   parameter  int MAX_OS_LOG2 = 6,
   parameter  int ODW         = 34,
   localparam int CHW         = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [2:0]            os_sel,
   input  logic                  in_valid,
   input  logic [CHW-1:0]        in_ch,
   input  logic signed [IDW-1:0] data_in,
   output logic                  out_valid,
   output logic [CHW-1:0]        out_ch,
   output logic [ODW-1:0]        data_out,
   output logic [CH-1:0]         ovf
);

   localparam int SHW = $clog2(ODW + 1);

   typedef struct packed {
      logic           vld;
      logic [CHW-1:0] ch;
      logic [ODW-1:0] x;
   } tok_t;

   tok_t           in_q, in_d;
   tok_t           stg_q [ORDER];
   tok_t           stg_d [ORDER];
   tok_t           src_w [ORDER];
   logic [ODW-1:0] acc_q [CH][ORDER];
   logic [ODW-1:0] acc_d [CH][ORDER];
   logic [ODW:0]   sum_w [ORDER];
   logic signed [ODW-1:0] shl_w  [ORDER];
   logic [ODW-1:0]        wrap_w [ORDER];
   logic [CH-1:0]  ovf_q, ovf_d;
   logic [2:0]     os_shadow_q;
   logic [SHW-1:0] shift_amt;

   // Wrapping to W bits is done as (s << (ODW-W)) >>> (ODW-W), which keeps s[W-1:0]
   // and sign-extends bit W-1 in one shifter pair.
   always_comb begin
      if (int'(os_shadow_q) > MAX_OS_LOG2) begin
         shift_amt = '0;
      end else begin
         shift_amt = SHW'(ODW - IDW - ORDER * int'(os_shadow_q));
      end
   end

   // NOTE: every variable written in this block gets a default first, so no latch is inferred.
   always_comb begin
      in_d.vld = in_valid && (int'(in_ch) < CH);
      in_d.ch  = in_ch;
      in_d.x   = {{(ODW-IDW){data_in[IDW-1]}}, data_in};
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      for (int k = 0; k < ORDER; k++) begin
         src_w[k]  = (k == 0) ? in_q : stg_q[(k == 0) ? 0 : k-1];
         sum_w[k]  = {acc_q[src_w[k].ch][k][ODW-1], acc_q[src_w[k].ch][k]}
                   + {src_w[k].x[ODW-1], src_w[k].x};
         shl_w[k]  = sum_w[k][ODW-1:0] << shift_amt;
         wrap_w[k] = shl_w[k] >>> shift_amt;
         stg_d[k]  = '{vld: src_w[k].vld, ch: src_w[k].ch, x: wrap_w[k]};
         if (src_w[k].vld) begin
            acc_d[src_w[k].ch][k] = wrap_w[k];
         end
         // Only the last stage's true overflow is reported; earlier wraps cancel in the comb.
         if (k == ORDER-1 && src_w[k].vld && ({wrap_w[k][ODW-1], wrap_w[k]} != sum_w[k])) begin
            ovf_d[src_w[k].ch] = 1'b1;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all stages update from the same pre-edge values.
   // NOTE: the accumulator array is reset because integrator state is architectural, not scratch data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q        <= '0;
         stg_q       <= '{default: '0};
         acc_q       <= '{default: '0};
         ovf_q       <= '0;
         os_shadow_q <= '0;
      end else if (clear) begin
         in_q        <= '0;
         stg_q       <= '{default: '0};
         acc_q       <= '{default: '0};
         ovf_q       <= '0;
         os_shadow_q <= os_sel;
      end else begin
         in_q  <= in_d;
         stg_q <= stg_d;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = stg_q[ORDER-1].vld;
   assign out_ch    = stg_q[ORDER-1].ch;
   assign data_out  = stg_q[ORDER-1].x;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Scoreboard bench for cic_integrator_chain: stimulus pushes expected outputs, a negedge
// monitor pops and compares. CH=3 so that an out-of-range channel index (3) is expressible.
module tb_cic_integrator_chain;

   localparam int IDW = 16, ORDER = 3, CH = 3, MAX_OS_LOG2 = 6, ODW = 34;
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   logic                  clk = 1'b0;
   logic                  reset, clear, in_valid;
   logic [2:0]            os_sel;
   logic [CHW-1:0]        in_ch;
   logic signed [IDW-1:0] data_in;
   logic                  out_valid;
   logic [CHW-1:0]        out_ch;
   logic [ODW-1:0]        data_out;
   logic [CH-1:0]         ovf;

   cic_integrator_chain #(
      .IDW(IDW), .ORDER(ORDER), .CH(CH), .MAX_OS_LOG2(MAX_OS_LOG2), .ODW(ODW)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .os_sel(os_sel),
      .in_valid(in_valid), .in_ch(in_ch), .data_in(data_in),
      .out_valid(out_valid), .out_ch(out_ch), .data_out(data_out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CHW-1:0] ch;
      logic [ODW-1:0] data;
      logic [CH-1:0]  ovf;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            check("data_out", 64'(data_out), 64'(e.data));
            check("out_ch",   64'(out_ch),   64'(e.ch));
            check("ovf",      64'(ovf),      64'(e.ovf));
         end
      end
   end

   function automatic longint wrapw(longint v, int w);
      longint m;
      m = v & ((64'sd1 <<< w) - 1);
      if (m >= (64'sd1 <<< (w-1))) m -= (64'sd1 <<< w);
      return m;
   endfunction

   task automatic push_exp(logic [CHW-1:0] ch, longint v, logic [CH-1:0] ov);
      q.push_back('{ch: ch, data: ODW'(v), ovf: ov});
   endtask

   task automatic send(logic [CHW-1:0] ch, logic signed [IDW-1:0] d);
      in_valid = 1'b1; in_ch = ch; data_in = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_clear(logic [2:0] os);
      clear = 1'b1; os_sel = os;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic drain(string name);
      for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
      #1;
      check(name, 64'(q.size()), 64'd0);
      idle(4);
   endtask

   // Constant-one stream: stage 2 holds n(n+1)/2 (never wraps for n<=60), so the final
   // stage is wrap(prev + n(n+1)/2); the ovf expectation is sticky from the first real wrap.
   task automatic run_ones(logic [CHW-1:0] ch, int n, int w);
      longint prev = 0, pre, wv;
      bit     sticky = 1'b0;
      for (int i = 1; i <= n; i++) begin
         pre = prev + longint'(i) * (i + 1) / 2;
         wv  = wrapw(pre, w);
         if (wv != pre) sticky = 1'b1;
         prev = wv;
         push_exp(ch, wv, sticky ? (CH'(1) << ch) : '0);
         send(ch, 16'sd1);
      end
   endtask

   longint imp_tab [4] = '{1, 3, 6, 10};
   longint tri_tab [4] = '{1, 4, 10, 20};
   longint str_tab [6] = '{1, 4, 10, 20, 35, 56};

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; clear = 1'b0; os_sel = 3'd0;
      in_valid = 1'b0; in_ch = '0; data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_data_out",  64'(data_out),  64'd0);
      check("reset_out_ch",    64'(out_ch),    64'd0);
      check("reset_ovf",       64'(ovf),       64'd0);
      reset = 1'b0;
      idle(1);

      // Impulse at W=22, with a latency probe around the third edge.
      do_clear(3'd2);
      for (int i = 0; i < 4; i++) push_exp(0, imp_tab[i], '0);
      send(0, 16'sd1);
      send(0, 16'sd0);
      send(0, 16'sd0);
      check("impulse_latency_before", 64'(out_valid), 64'd0);
      send(0, 16'sd0);
      check("impulse_latency_at", 64'(out_valid), 64'd1);
      drain("impulse_drain");

      // Interleaved channels with opposite-sign constant streams.
      do_clear(3'd2);
      for (int i = 0; i < 4; i++) begin
         push_exp(0, tri_tab[i], '0);
         send(0, 16'sd1);
         push_exp(1, -tri_tab[i], '0);
         send(1, -16'sd1);
      end
      drain("interleave_drain");

      // Wrap at W=16: output 57 is 32509, output 58 wraps to -31316 and sets ovf[0].
      do_clear(3'd0);
      run_ones(0, 60, 16);
      drain("wrap_drain");
      check("wrap_ovf_sticky", 64'(ovf), 64'd1);

      // Clear with three samples in flight plus a coincident sample; none may emerge.
      send(0, 16'sd100);
      send(0, 16'sd100);
      send(0, 16'sd100);
      in_valid = 1'b1; in_ch = 0; data_in = 16'sd77;
      clear = 1'b1; os_sel = 3'd6;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      check("clear_ovf", 64'(ovf), 64'd0);
      idle(4);
      for (int i = 0; i < 3; i++) push_exp(0, imp_tab[i], '0);
      send(0, 16'sd1);
      send(0, 16'sd0);
      send(0, 16'sd0);
      drain("clear_drain");

      // Gaps and an out-of-range channel: accumulators hold, dropped sample is invisible.
      do_clear(3'd6);
      push_exp(0, 1, '0);
      send(0, 16'sd1);
      idle(2);
      send(2'd3, 16'sd500);
      idle(1);
      push_exp(0, 3, '0);
      send(0, 16'sd0);
      idle(3);
      push_exp(0, 6, '0);
      send(0, 16'sd0);
      drain("gaps_drain");

      // Asynchronous reset between edges while ch1 is streaming.
      do_clear(3'd6);
      for (int i = 0; i < 6; i++) begin
         push_exp(1, str_tab[i], '0);
         send(1, 16'sd1);
      end
      #2;
      check("pre_reset_out_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      #1;
      check("async_out_valid", 64'(out_valid), 64'd0);
      check("async_data_out",  64'(data_out),  64'd0);
      check("async_out_ch",    64'(out_ch),    64'd0);
      check("async_ovf",       64'(ovf),       64'd0);
      q.delete();
      idle(1);
      #3;
      reset = 1'b0;
      @(posedge clk); #1;

      // After reset the shadow is 0 (W=16) even though os_sel now reads 6.
      os_sel = 3'd6;
      run_ones(0, 60, 16);
      drain("post_reset_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
